// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and load/store.
// Each grant runs IDLE -> ISSUE -> (WAIT) -> DONE; all outputs come straight from flops.
module mem_port_arbiter #(
  parameter int AW      = 11,
  parameter int DW      = 32,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          ram_ena,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic       last_d;   // last grant went to the data port
  logic       g_d;      // current transaction belongs to the data port
  logic       g_we;
  logic       grant, pick_d, cap, fin;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    grant   = 1'b0;
    pick_d  = 1'b0;
    cap     = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: if (if_req || d_req) begin
        grant   = 1'b1;
        // On conflict the port that did not win last time goes first.
        pick_d  = d_req && (!if_req || !last_d);
        state_n = ISSUE;
      end
      ISSUE: if (g_we) begin
        fin     = 1'b1;
        state_n = DONE;
      end else begin
        cnt_n   = 2'(RAM_LAT - 1);
        state_n = WAIT;
      end
      WAIT: if (cnt != 2'd0) begin
        cnt_n = cnt - 2'd1;
      end else begin
        cap     = 1'b1;
        fin     = 1'b1;
        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_d    <= 1'b0;
      g_d       <= 1'b0;
      g_we      <= 1'b0;
      ram_ena   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ram_ena <= grant;
      // Fetches never write, whatever d_we happens to be.
      ram_we  <= grant & pick_d & d_we;
      if (grant) begin
        g_d       <= pick_d;
        g_we      <= pick_d & d_we;
        last_d    <= pick_d;
        ram_addr  <= pick_d ? d_addr : if_addr;
        ram_wdata <= pick_d ? d_wdata : '0;
      end
      if (cap) begin
        if (g_d) d_rdata  <= ram_rdata;
        else     if_rdata <= ram_rdata;
      end
      if_ack <= fin & ~g_d;
      d_ack  <= fin & g_d;
      busy   <= (state_n != IDLE);
    end
  end

endmodule
